// File: rtl/uart_apb_master.sv
`default_nettype none
// ============================================================================
// Module      : uart_apb_master
// Description : Turns words received over a UART into APB transfers. Each
//               frame is a command word (bit31 = write, low ADDR_W bits =
//               address) optionally followed by a write-data word. Exactly
//               one APB transfer is issued per frame, and the read data or
//               status is returned on one-cycle strobes.
//               Optional feature macro: UART_APB_TIMEOUT_EN (PREADY timeout).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_apb_master #(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Rx_DV,
    input  logic [31:0]       i_Rx_Word,
    output logic [ADDR_W-1:0] o_PADDR,
    output logic              o_PSEL,
    output logic              o_PENABLE,
    output logic              o_PWRITE,
    output logic [31:0]       o_PWDATA,
    input  logic [31:0]       i_PRDATA,
    input  logic              i_PREADY,
    input  logic              i_PSLVERR,
    output logic              o_Rd_DV,
    output logic [31:0]       o_Rd_Data,
    output logic              o_Busy,
    output logic              o_Err,
    output logic              o_Overrun
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t            state;
    state_t            next_state;

    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [31:0]       pwdata;
    logic [31:0]       rd_data;
    logic              err_flag;
    logic              overrun;
    logic              timeout_hit;
    logic              busy_xfer;

    // Upper command bits above the address field carry no meaning.
    logic              unused_word_bits;
    assign unused_word_bits = ^i_Rx_Word;

    // Phases in which a new word cannot be accepted.
    assign busy_xfer = (state == S_SETUP) || (state == S_ACCESS) || (state == S_RESP);

`ifdef UART_APB_TIMEOUT_EN
    // Counter wide enough for TIMEOUT_CYCLES, kept within 8..32 bits.
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt;

    // Count ACCESS cycles spent without PREADY; cleared in SETUP so it is zero on entry.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            tmo_cnt <= '0;
        end else if (state == S_SETUP) begin
            tmo_cnt <= '0;
        end else if ((state == S_ACCESS) && !i_PREADY) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    // The last allowed ACCESS cycle without PREADY aborts; PREADY in that cycle wins.
    assign timeout_hit = (state == S_ACCESS) && !i_PREADY && (tmo_cnt == TMO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode for the frame/transfer sequence.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (i_Rx_DV) begin
                    next_state = i_Rx_Word[31] ? S_DATA : S_SETUP;
                end
            end
            S_DATA: begin
                if (i_Rx_DV) begin
                    next_state = S_SETUP;
                end
            end
            S_SETUP: begin
                next_state = S_ACCESS;
            end
            S_ACCESS: begin
                if (i_PREADY || timeout_hit) begin
                    next_state = S_RESP;
                end
            end
            S_RESP: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Command/data latching, completion capture and the overrun strobe.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            paddr    <= '0;
            pwrite   <= 1'b0;
            pwdata   <= '0;
            rd_data  <= '0;
            err_flag <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= i_Rx_DV && busy_xfer;
            case (state)
                S_IDLE: begin
                    if (i_Rx_DV) begin
                        pwrite <= i_Rx_Word[31];
                        paddr  <= i_Rx_Word[ADDR_W-1:0];
                    end
                end
                S_DATA: begin
                    if (i_Rx_DV) begin
                        pwdata <= i_Rx_Word;
                    end
                end
                S_ACCESS: begin
                    if (i_PREADY) begin
                        err_flag <= i_PSLVERR;
                        if (!pwrite) begin
                            rd_data <= i_PRDATA;
                        end
                    end else if (timeout_hit) begin
                        err_flag <= 1'b1;
                        if (!pwrite) begin
                            rd_data <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // APB control and status strobes decode directly from state, so an
    // asynchronous reset drops PSEL/PENABLE at once.
    always_comb begin
        o_PSEL    = (state == S_SETUP) || (state == S_ACCESS);
        o_PENABLE = (state == S_ACCESS);
        o_Busy    = (state != S_IDLE);
        o_Rd_DV   = (state == S_RESP) && !pwrite;
        o_Err     = (state == S_RESP) && err_flag;
    end

    assign o_PADDR   = paddr;
    assign o_PWRITE  = pwrite;
    assign o_PWDATA  = pwdata;
    assign o_Rd_Data = rd_data;
    assign o_Overrun = overrun;

endmodule
`default_nettype wire
